// File: rtl/rom_arb_pkg.sv
// Shared types for the two-master boot/program ROM read arbiter.
package rom_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic mst_idx_t;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-way round-robin grant; the pointer moves away from the master just served.
module rom_rr_arbiter
  import rom_arb_pkg::*;
(
  input  logic     ACLK,
  input  logic     ARESET,
  input  logic [1:0] req,
  input  logic     advance,
  input  mst_idx_t served,
  output mst_idx_t grant
);

  mst_idx_t ptr_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~served;
    end
  end

  always_comb begin
    grant = ptr_q;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one single-port ROM between two AXI read masters, round-robin per burst,
// issuing one ROM word read per cycle while the granted master keeps up.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [31:0]       ARADDR_M0,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [31:0]       ARADDR_M1,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  input  logic [DATA_W-1:0] ROM_out,
  output logic              ROM_enable,
  output logic              ROM_read,
  output logic [ADDR_W-1:0] ROM_address
);

  state_t            state;
  mst_idx_t          gnt_q;
  mst_idx_t          gnt_c;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    issued_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              fresh_q;
  logic [DATA_W-1:0] hold_q;

  logic              rready_g;
  logic              accept;
  logic              burst_issue;
  logic              issue;
  logic              done;
  logic [ADDR_W-1:0] ar_addr;
  logic [LEN_W-1:0]  ar_len;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] rdata_c;
  logic              addr_unused;

  assign addr_unused = ^{ARADDR_M0[31:ADDR_W+2], ARADDR_M0[1:0],
                         ARADDR_M1[31:ADDR_W+2], ARADDR_M1[1:0]};

  rom_rr_arbiter u_rr (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .req     ({ARVALID_M1, ARVALID_M0}),
    .advance (done),
    .served  (gnt_q),
    .grant   (gnt_c)
  );

  assign rready_g    = gnt_q ? RREADY_M1 : RREADY_M0;
  assign ar_addr     = gnt_c ? ARADDR_M1[ADDR_W+1:2] : ARADDR_M0[ADDR_W+1:2];
  assign ar_len      = gnt_c ? ARLEN_M1 : ARLEN_M0;
  assign ar_id       = gnt_c ? ARID_M1 : ARID_M0;
  assign accept      = (state == IDLE) && (ARVALID_M0 || ARVALID_M1) && !ARESET;
  assign burst_issue = (state == BURST) && (issued_q <= {1'b0, len_q}) &&
                       (!rvalid_q || rready_g) && !ARESET;
  assign issue       = accept || burst_issue;
  assign done        = (state == BURST) && rvalid_q && rlast_q && rready_g;
  assign issue_addr  = accept ? ar_addr : addr_q + ADDR_W'(1);

  assign ROM_enable  = issue;
  assign ROM_read    = issue;
  assign ROM_address = issue ? issue_addr : '0;
  assign ARREADY_M0  = accept && (gnt_c == 1'b0);
  assign ARREADY_M1  = accept && (gnt_c == 1'b1);

  // ROM_out is only valid right after a read; later stall cycles replay the copy
  assign rdata_c = fresh_q ? ROM_out : hold_q;

  always_comb begin
    RVALID_M0 = rvalid_q && (gnt_q == 1'b0);
    RVALID_M1 = rvalid_q && (gnt_q == 1'b1);
    RLAST_M0  = rlast_q && (gnt_q == 1'b0);
    RLAST_M1  = rlast_q && (gnt_q == 1'b1);
    RDATA_M0  = (gnt_q == 1'b0) ? rdata_c : '0;
    RDATA_M1  = (gnt_q == 1'b1) ? rdata_c : '0;
    RID_M0    = (gnt_q == 1'b0) ? id_q : '0;
    RID_M1    = (gnt_q == 1'b1) ? id_q : '0;
    RRESP_M0  = RRESP_OKAY;
    RRESP_M1  = RRESP_OKAY;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      gnt_q    <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      fresh_q  <= 1'b0;
      hold_q   <= '0;
    end else begin
      fresh_q <= issue;
      if (fresh_q) begin
        hold_q <= ROM_out;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BURST;
            gnt_q    <= gnt_c;
            id_q     <= ar_id;
            len_q    <= ar_len;
            addr_q   <= ar_addr;
            issued_q <= (LEN_W+1)'(1);
            rvalid_q <= 1'b1;
            rlast_q  <= (ar_len == '0);
          end
        end
        BURST: begin
          if (burst_issue) begin
            addr_q   <= issue_addr;
            issued_q <= issued_q + (LEN_W+1)'(1);
            rvalid_q <= 1'b1;
            rlast_q  <= (issued_q == {1'b0, len_q});
          end else if (rvalid_q && rready_g) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench: drivers push expected beats on AR acceptance, a monitor checks R beats.
module tb_rom_read_arbiter;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [7:0]  ARID_M0 = '0, ARID_M1 = '0;
  logic [31:0] ARADDR_M0 = '0, ARADDR_M1 = '0;
  logic [3:0]  ARLEN_M0 = '0, ARLEN_M1 = '0;
  logic        ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
  logic        ARREADY_M0, ARREADY_M1;
  logic [7:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
  logic        RREADY_M0 = 1'b1, RREADY_M1 = 1'b1;
  logic [31:0] ROM_out = '0;
  logic        ROM_enable, ROM_read;
  logic [11:0] ROM_address;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_served = 1;
  int acc_cyc = 0;
  int rmode [2] = '{0, 0};
  beat_t q0[$], q1[$];
  int acc_log[$];
  logic [11:0] rom_log[$];
  int beat_cyc0[$], beat_cyc1[$];
  logic ps [2] = '{1'b0, 1'b0};
  logic [31:0] pd [2];

  rom_read_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
    .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0),
    .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
    .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1),
    .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ROM_out(ROM_out), .ROM_enable(ROM_enable), .ROM_read(ROM_read),
    .ROM_address(ROM_address)
  );

  always #5 ACLK = ~ACLK;

  // ROM: word i holds i, data appears the cycle after an enabled read
  initial forever begin
    @(posedge ACLK);
    if (ROM_enable) ROM_out <= {20'd0, ROM_address};
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial forever begin
    @(posedge ACLK);
    #1;
    case (rmode[0])
      0: RREADY_M0 = 1'b1;
      1: RREADY_M0 = ~RREADY_M0;
      default: RREADY_M0 = 1'($urandom_range(0, 1));
    endcase
    case (rmode[1])
      0: RREADY_M1 = 1'b1;
      1: RREADY_M1 = ~RREADY_M1;
      default: RREADY_M1 = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic set_ar(input int m, input logic v, input logic [7:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    if (m == 0) begin
      ARVALID_M0 = v; ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len;
    end else begin
      ARVALID_M1 = v; ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len;
    end
  endtask

  task automatic push_burst(input int m, input logic [7:0] id,
                            input logic [31:0] addr, input logic [3:0] len);
    beat_t b;
    int word;
    word = int'(addr[13:2]);
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.data = 32'((word + i) % 4096);
      b.last = (i == int'(len));
      if (m == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic drive_ar(input int m, input logic [7:0] id,
                          input logic [31:0] addr, input logic [3:0] len);
    logic got;
    got = 1'b0;
    set_ar(m, 1'b1, id, addr, len);
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge ACLK);
      got = (m == 0) ? ARREADY_M0 : ARREADY_M1;
    end
    chk("ar_accept_timeout", 64'(got), 64'(1));
    if (got) push_burst(m, id, addr, len);
    @(posedge ACLK);
    #1;
    set_ar(m, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || RVALID_M0 || RVALID_M1) && n < 2000) begin
      @(negedge ACLK);
      n++;
    end
    chk("drain_timeout", 64'(n < 2000), 64'(1));
    @(posedge ACLK);
    #1;
  endtask

  task automatic score(input int m, input logic v, input logic rd, input logic [7:0] id,
                       input logic [31:0] data, input logic last, input logic [1:0] resp);
    beat_t b;
    if (ps[m]) begin
      chk("stall_valid_held", 64'(v), 64'(1));
      chk("stall_data_held", 64'(data), 64'(pd[m]));
    end
    if (v && !rd) chk("rom_idle_during_stall", 64'(ROM_enable), 64'(0));
    if (v && rd) begin
      chk("beat_expected", 64'((m == 0) ? q0.size() != 0 : q1.size() != 0), 64'(1));
      if (m == 0 && q0.size() != 0) begin
        b = q0.pop_front();
        beat_cyc0.push_back(cyc);
      end else if (m == 1 && q1.size() != 0) begin
        b = q1.pop_front();
        beat_cyc1.push_back(cyc);
      end else begin
        b = '0;
      end
      chk($sformatf("rdata_m%0d", m), 64'(data), 64'(b.data));
      chk($sformatf("rid_m%0d", m), 64'(id), 64'(b.id));
      chk($sformatf("rlast_m%0d", m), 64'(last), 64'(b.last));
      chk($sformatf("rresp_m%0d", m), 64'(resp), 64'(0));
    end
    ps[m] = v && !rd;
    pd[m] = data;
  endtask

  // monitor
  initial forever begin
    int exp_g;
    @(negedge ACLK);
    if (ARESET) begin
      ps[0] = 1'b0;
      ps[1] = 1'b0;
    end else begin
      if (ARREADY_M0 || ARREADY_M1) begin
        chk("arready_without_arvalid",
            64'((ARREADY_M0 && !ARVALID_M0) || (ARREADY_M1 && !ARVALID_M1)), 64'(0));
        if (ARVALID_M0 && ARVALID_M1) exp_g = (last_served == 0) ? 1 : 0;
        else exp_g = ARVALID_M1 ? 1 : 0;
        chk("arready_m0", 64'(ARREADY_M0), 64'(exp_g == 0));
        chk("arready_m1", 64'(ARREADY_M1), 64'(exp_g == 1));
        acc_log.push_back(ARREADY_M1 ? 1 : 0);
        acc_cyc = cyc;
        last_served = exp_g;
      end
      if (ROM_enable || ROM_read) chk("rom_read_eq_enable", 64'(ROM_read), 64'(ROM_enable));
      if (ROM_enable) rom_log.push_back(ROM_address);
      if (RVALID_M0 || RVALID_M1) chk("rvalid_exclusive", 64'(RVALID_M0 && RVALID_M1), 64'(0));
      score(0, RVALID_M0, RREADY_M0, RID_M0, RDATA_M0, RLAST_M0, RRESP_M0);
      score(1, RVALID_M1, RREADY_M1, RID_M1, RDATA_M1, RLAST_M1, RRESP_M1);
    end
  end

  task automatic clear_logs();
    acc_log.delete();
    rom_log.delete();
    beat_cyc0.delete();
    beat_cyc1.delete();
  endtask

  initial begin
    int word;
    logic [31:0] a;
    // reset state, with requests present to show ARREADY is held off
    ARVALID_M0 = 1'b1;
    ARVALID_M1 = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arready_m0", 64'(ARREADY_M0), 64'(0));
    chk("rst_arready_m1", 64'(ARREADY_M1), 64'(0));
    chk("rst_rvalid", 64'({RVALID_M0, RVALID_M1}), 64'(0));
    chk("rst_rlast", 64'({RLAST_M0, RLAST_M1}), 64'(0));
    chk("rst_rom_enable", 64'({ROM_enable, ROM_read}), 64'(0));
    chk("rst_rom_address", 64'(ROM_address), 64'(0));
    chk("rst_rdata", 64'(RDATA_M0 | RDATA_M1), 64'(0));
    @(posedge ACLK);
    #1;
    ARVALID_M0 = 1'b0;
    ARVALID_M1 = 1'b0;
    last_served = 1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // both masters contending, single beats
    clear_logs();
    repeat (3) begin
      fork
        drive_ar(0, 8'($urandom), $urandom, 4'd0);
        drive_ar(1, 8'($urandom), $urandom, 4'd0);
      join
    end
    wait_drain();
    chk("t2_accept_count", 64'(acc_log.size()), 64'(6));
    if (acc_log.size() >= 3) begin
      chk("t2_order0", 64'(acc_log[0]), 64'(0));
      chk("t2_order1", 64'(acc_log[1]), 64'(1));
      chk("t2_order2", 64'(acc_log[2]), 64'(0));
    end

    // M0 4-beat burst from word 4, full throughput
    clear_logs();
    drive_ar(0, 8'h11, 32'h10, 4'd3);
    wait_drain();
    chk("t1_rom_reads", 64'(rom_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < rom_log.size(); k++)
      chk("t1_rom_addr", 64'(rom_log[k]), 64'(4 + k));
    chk("t1_beats", 64'(beat_cyc0.size()), 64'(4));
    for (int k = 0; k < beat_cyc0.size(); k++)
      chk("t1_beat_cycle", 64'(beat_cyc0[k]), 64'(acc_cyc + 1 + k));

    // M1 burst under alternating RREADY
    clear_logs();
    rmode[1] = 1;
    a = $urandom;
    word = int'(a[13:2]);
    drive_ar(1, 8'h33, a, 4'd3);
    wait_drain();
    rmode[1] = 0;
    chk("t3_beats", 64'(beat_cyc1.size()), 64'(4));
    chk("t3_rom_reads", 64'(rom_log.size()), 64'(4));
    for (int k = 0; k < rom_log.size(); k++)
      chk("t3_rom_addr", 64'(rom_log[k]), 64'((word + k) % 4096));

    // address wrap at the top of the ROM, upper ARADDR bits ignored
    clear_logs();
    drive_ar(0, 8'h44, 32'h1234_3FFC, 4'd1);
    wait_drain();
    chk("t4_rom_reads", 64'(rom_log.size()), 64'(2));
    if (rom_log.size() == 2) begin
      chk("t4_rom_addr0", 64'(rom_log[0]), 64'(12'hFFF));
      chk("t4_rom_addr1", 64'(rom_log[1]), 64'(12'h000));
    end

    // reset in the middle of a burst, then a fresh single beat on M1
    drive_ar(0, 8'h55, 32'h200, 4'd3);
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    ARVALID_M1 = 1'b1;
    #1;
    chk("t5_rvalid_m0", 64'(RVALID_M0), 64'(0));
    chk("t5_arready_m1", 64'(ARREADY_M1), 64'(0));
    chk("t5_rom_enable", 64'(ROM_enable), 64'(0));
    q0.delete();
    last_served = 1;
    @(posedge ACLK);
    #1;
    ARVALID_M1 = 1'b0;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    clear_logs();
    drive_ar(1, 8'hA5, $urandom, 4'd0);
    wait_drain();
    chk("t5_beats", 64'(beat_cyc1.size()), 64'(1));

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      rmode[0] = int'($urandom_range(0, 2));
      rmode[1] = int'($urandom_range(0, 2));
      fork
        if (sel != 1) drive_ar(0, 8'($urandom), $urandom, 4'($urandom));
        if (sel != 0) drive_ar(1, 8'($urandom), $urandom, 4'($urandom));
      join
      wait_drain();
    end
    rmode[0] = 0;
    rmode[1] = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
